// File: rtl/invaders_engine.sv
// Invader formation core: marches a 20-column row on a speed-timer tick, drops a line at each wall,
// clears invaders hit by the player bullet and flags win/lose. Define INVADERS_LEVEL_SPEED_EN to scale the tick period by level.
module invaders_engine #(
  parameter int unsigned BASE_TICKS   = 3600000,
  parameter logic [19:0] INIT_PATTERN = 20'b01010101010101010101,
  parameter logic [3:0]  LAST_LINE    = 4'd14
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  bullet_x,
  input  logic [3:0]  bullet_y,
  input  logic [2:0]  level,
  output logic [19:0] invaders_array,
  output logic [3:0]  invaders_line,
  output logic        hit,
  output logic        game_over,
  output logic        win
);

  localparam int unsigned CW = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
  localparam logic [CW-1:0] PM1_RESET = (BASE_TICKS > 1) ? CW'(BASE_TICKS - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WIN, S_LOSE} state_t;

  state_t        state;
  logic          dir;
  logic [CW-1:0] count;
  logic [CW-1:0] period_m1;
  logic [CW-1:0] period_m1_next;
  logic          q;
  logic [31:0]   ticks_lvl;
  logic [19:0]   hit_mask;
  logic [19:0]   arr_cleared;
  logic [19:0]   arr_next;
  logic [3:0]    line_next;
  logic          dir_next;
  logic          hit_now;

`ifdef INVADERS_LEVEL_SPEED_EN
  assign ticks_lvl = 32'(BASE_TICKS) >> level;
`else
  logic unused_level;
  assign unused_level = ^level;
  assign ticks_lvl    = 32'(BASE_TICKS);
`endif

  // Period is stored minus one so the reload compare needs no adder; shifts below 1 clamp to a 1-cycle period.
  assign period_m1_next = (ticks_lvl <= 32'd1) ? '0 : CW'(ticks_lvl - 32'd1);

  assign hit_mask = (bullet_x < 5'd20) ? (20'd1 << bullet_x) : '0;

  // Movement works on the already-cleared row, so shooting the edge invader lets the row shift instead of descend.
  always_comb begin
    hit_now     = 1'b0;
    arr_cleared = invaders_array;
    if (state == S_RUN && bullet_y == invaders_line && (invaders_array & hit_mask) != '0) begin
      hit_now     = 1'b1;
      arr_cleared = invaders_array & ~hit_mask;
    end
    arr_next  = arr_cleared;
    line_next = invaders_line;
    dir_next  = dir;
    if (state == S_RUN && q && arr_cleared != '0) begin
      if (dir) begin
        if (arr_cleared[19]) begin
          line_next = invaders_line + 4'd1;
          dir_next  = 1'b0;
        end else begin
          arr_next = arr_cleared << 1;
        end
      end else begin
        if (arr_cleared[0]) begin
          line_next = invaders_line + 4'd1;
          dir_next  = 1'b1;
        end else begin
          arr_next = arr_cleared >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      invaders_array <= INIT_PATTERN;
      invaders_line  <= '0;
      dir            <= 1'b1;
      hit            <= 1'b0;
      count          <= '0;
      q              <= 1'b0;
      period_m1      <= PM1_RESET;
      game_over      <= 1'b0;
      win            <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        S_RUN: begin
          invaders_array <= arr_next;
          invaders_line  <= line_next;
          dir            <= dir_next;
          hit            <= hit_now;
          if (arr_next == '0) begin
            state <= S_WIN;
            win   <= 1'b1;
            count <= '0;
            q     <= 1'b0;
          end else if (line_next == LAST_LINE) begin
            state     <= S_LOSE;
            game_over <= 1'b1;
            count     <= '0;
            q         <= 1'b0;
          end else if (count == period_m1) begin
            count     <= '0;
            q         <= 1'b1;
            period_m1 <= period_m1_next;
          end else begin
            count <= count + CW'(1);
            q     <= 1'b0;
          end
        end
        default: begin
          // IDLE, WIN and LOSE hold the timer cleared and keep the period tracking level until RUN begins.
          count     <= '0;
          q         <= 1'b0;
          period_m1 <= period_m1_next;
          if (start) begin
            state          <= S_RUN;
            invaders_array <= INIT_PATTERN;
            invaders_line  <= '0;
            dir            <= 1'b1;
            win            <= 1'b0;
            game_over      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_invaders_engine.sv
// Self-checking bench for invaders_engine: directed opening moves, then randomized play against a cycle-level game model.
module tb_invaders_engine;

`ifdef INVADERS_LEVEL_SPEED_EN
  localparam int unsigned BT = 16;
`else
  localparam int unsigned BT = 4;
`endif
  localparam logic [19:0] INIT    = 20'b01010101010101010101;
  localparam logic [3:0]  LAST    = 4'd14;
  localparam int          M_IDLE  = 0;
  localparam int          M_RUN   = 1;
  localparam int          M_WIN   = 2;
  localparam int          M_LOSE  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  bullet_x = '0;
  logic [3:0]  bullet_y = 4'd15;
  logic [2:0]  level = 3'd2;
  logic [19:0] invaders_array;
  logic [3:0]  invaders_line;
  logic        hit;
  logic        game_over;
  logic        win;

  int n_cmp = 0;
  int n_err = 0;

  // Game model: spec-level state, with ticks derived from edges elapsed since the game started.
  int        m_state;
  bit [19:0] m_arr;
  bit [3:0]  m_line;
  bit        m_dir;
  bit        m_hit;
  int        m_run;
  int        m_period;

  invaders_engine #(
    .BASE_TICKS  (BT),
    .INIT_PATTERN(INIT),
    .LAST_LINE   (LAST)
  ) dut (
    .clk_36MHz     (clk),
    .reset         (reset),
    .start         (start),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .level         (level),
    .invaders_array(invaders_array),
    .invaders_line (invaders_line),
    .hit           (hit),
    .game_over     (game_over),
    .win           (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period_now();
    int p;
`ifdef INVADERS_LEVEL_SPEED_EN
    p = int'(BT >> level);
    if (p < 1) p = 1;
`else
    p = int'(BT);
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_arr   = INIT;
    m_line  = 0;
    m_dir   = 1'b1;
    m_hit   = 1'b0;
    m_run   = 0;
    m_period = period_now();
  endtask

  task automatic model_begin();
    m_state  = M_RUN;
    m_arr    = INIT;
    m_line   = 0;
    m_dir    = 1'b1;
    m_run    = 0;
    m_period = period_now();
  endtask

  task automatic model_step();
    bit [19:0] a;
    bit        tick;
    m_hit = 1'b0;
    if (m_state == M_RUN) begin
      m_run++;
      tick = (m_run > 1) && ((m_run - 1) % m_period == 0);
      a = m_arr;
      if (bullet_y == m_line && bullet_x < 20 && a[bullet_x]) begin
        a[bullet_x] = 1'b0;
        m_hit = 1'b1;
      end
      if (tick && a != 0) begin
        if (m_dir && a[19])       begin m_line = m_line + 1; m_dir = 1'b0; end
        else if (m_dir)           a = a * 2;
        else if (a[0])            begin m_line = m_line + 1; m_dir = 1'b1; end
        else                      a = a / 2;
      end
      m_arr = a;
      if (a == 0)              m_state = M_WIN;
      else if (m_line == LAST) m_state = M_LOSE;
    end else if (start) begin
      model_begin();
    end
  endtask

  task automatic compare_all();
    check("array", 32'(invaders_array), 32'(m_arr));
    check("line",  32'(invaders_line),  32'(m_line));
    check("hit",   32'(hit),            32'(m_hit));
    check("over",  32'(game_over),      32'(m_state == M_LOSE));
    check("win",   32'(win),            32'(m_state == M_WIN));
  endtask

  // One clock: inputs already driven; advance model on the edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [19:0] init_sh;
    int pct;
    init_sh = INIT << 1;
    pct = 0;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("idle_array", 32'(invaders_array), 32'(INIT));
    check("idle_line",  32'(invaders_line),  32'd0);
    check("idle_hit",   32'(hit),            32'd0);

    // Opening: first shift P+1 edges after start, right wall descends, then march left.
    bullet_y = 4'd2; bullet_x = 5'd2;
    cyc();
    check("idle_no_hit", 32'(invaders_array), 32'(INIT));
    bullet_y = 4'd15;
    level = 3'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= m_period; k++) cyc();
    check("pre_shift", 32'(invaders_array), 32'(INIT));
    cyc();
    check("first_shift", 32'(invaders_array), 32'(init_sh));
    for (int k = 0; k < m_period; k++) cyc();
    check("wall_line",  32'(invaders_line),  32'd1);
    check("wall_array", 32'(invaders_array), 32'(init_sh));
    for (int k = 0; k < m_period; k++) cyc();
    check("left_shift", 32'(invaders_array), 32'(INIT));

    bullet_y = 4'd1; bullet_x = 5'd2;
    cyc();
    check("hit_pulse", 32'(hit), 32'd1);
    check("hit_clear", 32'(invaders_array), 32'(INIT & ~20'h00004));
    cyc();
    check("hit_once", 32'(hit), 32'd0);
    bullet_x = 5'd25;
    cyc();
    check("x_ge_20", 32'(hit), 32'd0);
    bullet_y = 4'd15;

    // Randomized play: varied aim rates give both cleared rows and landings, with restarts.
    for (int c = 0; c < 15000; c++) begin
      start = 1'b0;
      if (m_state != M_RUN && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        level = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0:       pct = 0;
          1:       pct = 3;
          default: pct = 40;
        endcase
      end else if (m_state == M_RUN && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
      end
      if ($urandom_range(0, 99) < pct) begin
        bullet_y = ($urandom_range(0, 3) != 0) ? m_line : 4'($urandom_range(0, 15));
        bullet_x = 5'($urandom_range(0, 24));
      end else begin
        bullet_y = 4'd15;
        bullet_x = 5'($urandom_range(0, 31));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
